// File: rtl/timer_clock.sv
`default_nettype none
// ============================================================================
//  Module   : timer_clock
//  Purpose  : BCD countdown timer for one side of a chess clock. Holds the
//             remaining time as four BCD digits (MM:SS), loads a preset on
//             reset, decrements by one second on each qualified rising edge
//             of the 1 Hz IMPULSE tick while enabled, and raises a sticky
//             OVERFLOW flag when the time reaches 00:00.
//  Ports    : CLK        in  1  system clock, rising edge
//             CLR        in  1  asynchronous active-low reset
//             CE         in  1  count enable (this side is running)
//             IMPULSE    in  1  one-second tick, synchronous to CLK
//             sec_units  out 4  BCD seconds units, 0-9
//             sec_tens   out 4  BCD seconds tens, 0-5
//             min_units  out 4  BCD minutes units, 0-9
//             min_tens   out 4  BCD minutes tens, 0-9
//             OVERFLOW   out 1  time expired, sticky until reset
//  Params   : INIT_MINUTES  preset minutes, 0-99
//             INIT_SECONDS  preset seconds, 0-59 (preset must not be 00:00)
//  Revision : 1.0  initial release
// ============================================================================
module timer_clock #(
  parameter int INIT_MINUTES = 10,
  parameter int INIT_SECONDS = 0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       IMPULSE,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic       OVERFLOW
);

  // Preset digits, split once at elaboration time.
  localparam logic [3:0] c_init_min_tens  = 4'(INIT_MINUTES / 10);
  localparam logic [3:0] c_init_min_units = 4'(INIT_MINUTES % 10);
  localparam logic [3:0] c_init_sec_tens  = 4'(INIT_SECONDS / 10);
  localparam logic [3:0] c_init_sec_units = 4'(INIT_SECONDS % 10);

  // Wrap values used when a digit borrows from its neighbour.
  localparam logic [3:0] c_wrap_units = 4'd9;
  localparam logic [3:0] c_wrap_tens  = 4'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0] sec_units_q, sec_units_d;
  logic [3:0] sec_tens_q,  sec_tens_d;
  logic [3:0] min_units_q, min_units_d;
  logic [3:0] min_tens_q,  min_tens_d;
  logic       overflow_q,  overflow_d;
  logic       imp_prev_q,  imp_prev_d;

  logic       w_tick;
  logic       w_at_last;

  // One BCD digit step down: zero wraps to the supplied maximum (the caller
  // treats that case as a borrow into the next digit).
  function automatic logic [3:0] bcd_dec(input logic [3:0] digit,
                                         input logic [3:0] wrap);
    logic [3:0] result;
    if (digit == 4'd0) begin
      result = wrap;
    end else begin
      result = digit - 4'd1;
    end
    return result;
  endfunction

  // A tick is a fresh rising edge of IMPULSE seen while enabled and not yet
  // expired. imp_prev resets to 1 so a pulse already high at reset release
  // is not mistaken for an edge.
  assign w_tick = CE & IMPULSE & ~imp_prev_q & ~overflow_q;

  // The last remaining second (00:01). 00:00 is also folded in so the timer
  // can never wrap below zero even if the preset was misconfigured.
  assign w_at_last = (min_tens_q  == 4'd0) &&
                     (min_units_q == 4'd0) &&
                     (sec_tens_q  == 4'd0) &&
                     (sec_units_q <= 4'd1);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    sec_units_d = sec_units_q;
    sec_tens_d  = sec_tens_q;
    min_units_d = min_units_q;
    min_tens_d  = min_tens_q;
    overflow_d  = overflow_q;
    // Edge history tracks IMPULSE every cycle, so an edge seen while CE=0
    // is consumed and never counted later.
    imp_prev_d  = IMPULSE;

    if (w_tick) begin
      if (w_at_last) begin
        sec_units_d = 4'd0;
        sec_tens_d  = 4'd0;
        min_units_d = 4'd0;
        min_tens_d  = 4'd0;
        overflow_d  = 1'b1;
      end else begin
        // Ripple borrow: each digit only moves when every lower digit
        // was zero before this tick.
        sec_units_d = bcd_dec(sec_units_q, c_wrap_units);
        if (sec_units_q == 4'd0) begin
          sec_tens_d = bcd_dec(sec_tens_q, c_wrap_tens);
          if (sec_tens_q == 4'd0) begin
            min_units_d = bcd_dec(min_units_q, c_wrap_units);
            if (min_units_q == 4'd0) begin
              // Non-zero here because the all-zero case is handled above.
              min_tens_d = min_tens_q - 4'd1;
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sec_units_q <= c_init_sec_units;
      sec_tens_q  <= c_init_sec_tens;
      min_units_q <= c_init_min_units;
      min_tens_q  <= c_init_min_tens;
      overflow_q  <= 1'b0;
      imp_prev_q  <= 1'b1;
    end else begin
      sec_units_q <= sec_units_d;
      sec_tens_q  <= sec_tens_d;
      min_units_q <= min_units_d;
      min_tens_q  <= min_tens_d;
      overflow_q  <= overflow_d;
      imp_prev_q  <= imp_prev_d;
    end
  end

  // All outputs come straight from registers.
  assign sec_units = sec_units_q;
  assign sec_tens  = sec_tens_q;
  assign min_units = min_units_q;
  assign min_tens  = min_tens_q;
  assign OVERFLOW  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_clock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_clock
//  Purpose  : Scoreboard bench for timer_clock. Three instances share clock,
//             reset and IMPULSE: 10:00 (defaults), 01:00 and 99:59, each with
//             its own CE. Stimulus pushes expected time/overflow entries; a
//             monitor on the falling clock edge pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_clock;

  logic       CLK;
  logic       CLR;
  logic       IMPULSE;
  logic [2:0] ce;

  logic [3:0] su [3];
  logic [3:0] st [3];
  logic [3:0] mu [3];
  logic [3:0] mt [3];
  logic       ov [3];

  timer_clock u_dut0 (
    .CLK(CLK), .CLR(CLR), .CE(ce[0]), .IMPULSE(IMPULSE),
    .sec_units(su[0]), .sec_tens(st[0]), .min_units(mu[0]), .min_tens(mt[0]),
    .OVERFLOW(ov[0])
  );

  timer_clock #(.INIT_MINUTES(1), .INIT_SECONDS(0)) u_dut1 (
    .CLK(CLK), .CLR(CLR), .CE(ce[1]), .IMPULSE(IMPULSE),
    .sec_units(su[1]), .sec_tens(st[1]), .min_units(mu[1]), .min_tens(mt[1]),
    .OVERFLOW(ov[1])
  );

  timer_clock #(.INIT_MINUTES(99), .INIT_SECONDS(59)) u_dut2 (
    .CLK(CLK), .CLR(CLR), .CE(ce[2]), .IMPULSE(IMPULSE),
    .sec_units(su[2]), .sec_tens(st[2]), .min_units(mu[2]), .min_tens(mt[2]),
    .OVERFLOW(ov[2])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    int    inst;
    int    secs;
    bit    ovf;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: everything queued by the stimulus is compared at the next
  // falling edge, well away from the active edge.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] got, want;
      e    = sb.pop_front();
      got  = {mt[e.inst], mu[e.inst], st[e.inst], su[e.inst]};
      want = {4'((e.secs / 60) / 10), 4'((e.secs / 60) % 10),
              4'((e.secs % 60) / 10), 4'(e.secs % 10)};
      n_checks++;
      if (got === want && ov[e.inst] === e.ovf) begin
        n_pass++;
      end else begin
        $display("FAIL %s inst%0d: got %h%h:%h%h ovf=%b, expected %h%h:%h%h ovf=%b",
                 e.name, e.inst, got[15:12], got[11:8], got[7:4], got[3:0],
                 ov[e.inst], want[15:12], want[11:8], want[7:4], want[3:0],
                 e.ovf);
      end
    end
  end

  task automatic expect_t(input int inst, input int secs, input bit ovf,
                          input string name);
    exp_t e;
    e.inst = inst;
    e.secs = secs;
    e.ovf  = ovf;
    e.name = name;
    sb.push_back(e);
  endtask

  // Bounded wait for the monitor to consume the queue.
  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 8) begin
      @(negedge CLK);
      #1;
      k++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending entries, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // One minimum-spacing pulse; returns just after the edge that sees the rise.
  task automatic pulse();
    step(); IMPULSE = 1'b0;
    step(); IMPULSE = 1'b1;
    step();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int m;
    CLR     = 1'b1;
    IMPULSE = 1'b1;
    ce      = 3'b001;
    #3 CLR = 1'b0;

    // Reset values while held in reset.
    step();
    expect_t(0, 600, 1'b0, "reset_hold_10_00");
    expect_t(1, 60, 1'b0, "reset_hold_01_00");
    expect_t(2, 5999, 1'b0, "reset_hold_99_59");
    drain();

    // Release with IMPULSE already high and CE=1: no decrement.
    step(); CLR = 1'b1;
    repeat (10) step();
    expect_t(0, 600, 1'b0, "release_impulse_high");
    drain();

    // Single edge after IMPULSE low for 7 cycles, then held high.
    step(); IMPULSE = 1'b0;
    repeat (7) step();
    IMPULSE = 1'b1;
    step();
    expect_t(0, 599, 1'b0, "single_edge");
    drain();
    repeat (5) step();
    expect_t(0, 599, 1'b0, "held_high_stable");
    drain();

    // Back to 10:00 for the gating test.
    CLR = 1'b0;
    step();
    expect_t(0, 600, 1'b0, "reset_again");
    drain();
    CLR = 1'b1;

    ce[0] = 1'b0;
    repeat (5) pulse();
    expect_t(0, 600, 1'b0, "ce_low_gated");
    drain();
    ce[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      pulse();
      expect_t(0, 600 - i, 1'b0, "ce_high_pulses");
      drain();
    end

    // CE rising together with IMPULSE: sampled CE=1 decides, so it counts.
    step(); ce[0] = 1'b0; IMPULSE = 1'b0;
    step();
    ce[0] = 1'b1; IMPULSE = 1'b1;
    step();
    expect_t(0, 596, 1'b0, "ce_same_edge_rise");
    drain();

    // CE falling together with the rise: edge is lost, not deferred.
    step(); IMPULSE = 1'b0;
    step(); IMPULSE = 1'b1; ce[0] = 1'b0;
    step(); ce[0] = 1'b1;
    repeat (3) step();
    expect_t(0, 596, 1'b0, "ce_same_edge_fall_lost");
    drain();

    // Count down to 07:23 (443 s), then reset asynchronously between edges.
    m = 596;
    while (m > 443) begin
      pulse();
      m--;
    end
    expect_t(0, 443, 1'b0, "count_to_07_23");
    drain();
    step();
    #1 CLR = 1'b0;
    #1;
    expect_t(0, 600, 1'b0, "async_reset_mid_count");
    expect_t(1, 60, 1'b0, "async_reset_inst1");
    expect_t(2, 5999, 1'b0, "async_reset_inst2");
    drain();
    CLR = 1'b1;

    // Borrow chain from 01:00 down to overflow.
    ce = 3'b010;
    m  = 60;
    for (int i = 0; i < 60; i++) begin
      pulse();
      m--;
      expect_t(1, m, (m == 0), "borrow_chain");
      drain();
    end
    for (int i = 0; i < 3; i++) begin
      pulse();
      expect_t(1, 0, 1'b1, "overflow_sticky");
      drain();
    end

    // Full count from 99:59.
    ce = 3'b100;
    m  = 5999;
    for (int i = 0; i < 5999; i++) begin
      pulse();
      m--;
      expect_t(2, m, (m == 0), "full_count");
      drain();
    end
    pulse();
    expect_t(2, 0, 1'b1, "full_count_after_overflow");
    expect_t(0, 600, 1'b0, "inst0_idle_hold");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_clock.md
# timer_clock

BCD countdown timer for one player's side of the chess clock. It holds remaining time as four BCD digits (MM:SS) and loads a preset time on reset. It decrements by one second on each qualified rising edge of the 1 Hz `IMPULSE` tick while enabled, and raises a sticky `OVERFLOW` flag when time runs out. The parent clock instantiates two copies and uses `CE` to select the running side; the digits drive the display multiplexer.

## Interface
- `INIT_MINUTES`, default 10: preset minutes loaded on reset; 0–99.
- `INIT_SECONDS`, default 0: preset seconds loaded on reset; 0–59.
- Parameter constraint: the preset must not be 00:00.
- `CLK` in 1: system clock, all state changes on the rising edge.
- `CLR` in 1: one clock; reset is asynchronous and active-low (`CLR`=0 resets immediately, independent of `CLK`).
- `CE` in 1: count enable; 1 = this side is running.
- `IMPULSE` in 1: one-second tick, synchronous to `CLK`; only its rising edge counts.
- `sec_units` out 4: BCD seconds units, 0–9.
- `sec_tens` out 4: BCD seconds tens, 0–5.
- `min_units` out 4: BCD minutes units, 0–9.
- `min_tens` out 4: BCD minutes tens, 0–9.
- `OVERFLOW` out 1: time expired, sticky.

## Operation
- Internal `imp_prev` register holds `IMPULSE` from the previous clock. Its reset value is 1, so an `IMPULSE` already high at reset release does not count.
- `tick = CE & IMPULSE & ~imp_prev & ~OVERFLOW`.
- `imp_prev` updates every clock regardless of `CE`. A rising edge that occurs while `CE`=0 is lost, not deferred.
- On `tick`, decrement MM:SS by one second using BCD borrow:
  - `sec_units` 0→9 with borrow, else −1.
  - On borrow, `sec_tens` 0→5 with borrow, else −1.
  - On borrow, `min_units` 0→9 with borrow, else −1.
  - On borrow, `min_tens` −1.
- On the tick that produces 00:00, the digits become 0000 and `OVERFLOW` is set to 1 on the same edge.
- While `OVERFLOW`=1, digits hold at 00:00 and further ticks are ignored. Only reset clears it.
- Without a tick, all state holds.
- All outputs are registered; there are no combinational input-to-output paths.
- Digits always hold valid BCD within the ranges listed in the Interface.

## Timing
- Reset (`CLR`=0, asynchronous) sets:
  - `min_tens` = `INIT_MINUTES`/10, `min_units` = `INIT_MINUTES`%10.
  - `sec_tens` = `INIT_SECONDS`/10, `sec_units` = `INIT_SECONDS`%10.
  - `OVERFLOW` = 0, `imp_prev` = 1.
- Reset asserted mid-count or after overflow immediately restores the preset and clears `OVERFLOW`.
- Latency: the digits change at the first `CLK` rising edge where `IMPULSE`=1 after having been 0 at the previous edge, with `CE`=1. New values are visible after that edge, one-edge latency.
- `IMPULSE` held high for any number of cycles produces exactly one decrement.
- `IMPULSE` low for one cycle then high produces a decrement; minimum pulse spacing is 2 clocks.
- `CE` changing on the same edge as the `IMPULSE` rise: the `CE` value sampled at that edge decides.
- Full-borrow case 10:00 → 09:59 completes in one edge.
- Final-tick case 00:01 → 00:00 with `OVERFLOW`↑ completes in the same edge.

## Test plan
- Reset with defaults: `CLR`=0, then release with `IMPULSE`=1, `CE`=1 held for 10 cycles -> outputs 1,0,0,0 (min_tens..sec_units), `OVERFLOW`=0, no decrement.
- Single edge: from 10:00, drive `IMPULSE` 0 for 7 cycles then 1 -> exactly 09:59 one edge after the rise, then stable while `IMPULSE` stays 1.
- Enable gating: `CE`=0 while 5 `IMPULSE` pulses are applied -> time unchanged. Set `CE`=1 and apply 3 pulses -> 09:57.
- Borrow chain with `INIT`=01:00: one pulse -> 00:59; 59 more pulses -> 00:00 with `OVERFLOW`=1 on the same edge. Further pulses -> still 00:00 and `OVERFLOW`=1.
- Async reset mid-count: assert `CLR`=0 between clock edges at 07:23 -> outputs return to 10:00 and `OVERFLOW`=0 before the next `CLK` edge.
- Full count from 99:59 over 5999 pulses: `sec_tens` never exceeds 5, all digits stay valid BCD, and `OVERFLOW` asserts only on the final pulse.
